// File: rtl/i2s_tx.sv
// I2S transmitter: mck-derived bit clock, one-entry pending buffer, frame-aligned
// sample loading with underrun detection and a saturating underrun counter.
module i2s_tx #(
    parameter int unsigned FRAME   = 24,
    parameter int unsigned SLOT    = 32,
    parameter int unsigned MCK_DIV = 2
) (
    input  logic             mck_i,
    input  logic             rst_i,
    input  logic [FRAME-1:0] l_data_i,
    input  logic [FRAME-1:0] r_data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             bck_o,
    output logic             lrck_o,
    output logic             data_o,
    output logic             frame_o,
    output logic             underrun_o,
    output logic [7:0]       underrun_cnt_o
);

    localparam int unsigned DW = (MCK_DIV > 1) ? $clog2(MCK_DIV) : 1;
    localparam int unsigned BW = $clog2(2 * SLOT);
    localparam int unsigned IW = (FRAME > 1) ? $clog2(FRAME) : 1;

    localparam logic [DW-1:0] DivLast = DW'(MCK_DIV - 1);
    localparam logic [BW-1:0] BitLast = BW'(2 * SLOT - 1);
    localparam logic [BW-1:0] BitSlot = BW'(SLOT);

    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             bck_q, bck_d;
    logic             lrck_q, lrck_d;
    logic             data_q, data_d;
    logic             frame_q, frame_d;
    logic             underrun_q, underrun_d;
    logic [7:0]       ucnt_q, ucnt_d;
    logic             pend_valid_q, pend_valid_d;
    logic [FRAME-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic [FRAME-1:0] act_l_q, act_l_d, act_r_q, act_r_d;

    logic             fall;
    logic             accept;
    int unsigned      k;
    logic [IW-1:0]    idx;

    always_comb begin
        div_cnt_d    = div_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        bck_d        = bck_q;
        lrck_d       = lrck_q;
        data_d       = data_q;
        frame_d      = 1'b0;
        underrun_d   = 1'b0;
        ucnt_d       = ucnt_q;
        pend_valid_d = pend_valid_q;
        pend_l_d     = pend_l_q;
        pend_r_d     = pend_r_q;
        act_l_d      = act_l_q;
        act_r_d      = act_r_q;
        fall         = 1'b0;
        k            = 0;
        idx          = '0;
        accept       = valid_i && !pend_valid_q;

        if (div_cnt_q == DivLast) begin
            div_cnt_d = '0;
            bck_d     = ~bck_q;
            fall      = bck_q;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end

        if (fall) begin
            bit_cnt_d = (bit_cnt_q == BitLast) ? '0 : bit_cnt_q + 1'b1;
            if (bit_cnt_d == '0) begin
                lrck_d  = 1'b0;
                frame_d = 1'b1;
                if (pend_valid_q) begin
                    act_l_d      = pend_l_q;
                    act_r_d      = pend_r_q;
                    pend_valid_d = 1'b0;
                end else begin
                    act_l_d    = '0;
                    act_r_d    = '0;
                    underrun_d = 1'b1;
                    if (ucnt_q != 8'hFF) begin
                        ucnt_d = ucnt_q + 8'd1;
                    end
                end
            end else if (bit_cnt_d == BitSlot) begin
                lrck_d = 1'b1;
            end

            // Bit 0 of each slot is the one-bck I2S delay; bits past FRAME are padding.
            k      = int'(bit_cnt_d);
            data_d = 1'b0;
            if (k >= 1 && k <= FRAME) begin
                idx    = IW'(FRAME - k);
                data_d = act_l_q[idx];
            end else if (k >= SLOT + 1 && k <= SLOT + FRAME) begin
                idx    = IW'(SLOT + FRAME - k);
                data_d = act_r_q[idx];
            end
        end

        // Only reachable with the buffer empty, so a same-cycle frame start never loses it.
        if (accept) begin
            pend_l_d     = l_data_i;
            pend_r_d     = r_data_i;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge mck_i) begin
        if (rst_i) begin
            div_cnt_q    <= '0;
            bit_cnt_q    <= BitLast;
            bck_q        <= 1'b0;
            lrck_q       <= 1'b1;
            data_q       <= 1'b0;
            frame_q      <= 1'b0;
            underrun_q   <= 1'b0;
            ucnt_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_l_q     <= '0;
            pend_r_q     <= '0;
            act_l_q      <= '0;
            act_r_q      <= '0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            bck_q        <= bck_d;
            lrck_q       <= lrck_d;
            data_q       <= data_d;
            frame_q      <= frame_d;
            underrun_q   <= underrun_d;
            ucnt_q       <= ucnt_d;
            pend_valid_q <= pend_valid_d;
            pend_l_q     <= pend_l_d;
            pend_r_q     <= pend_r_d;
            act_l_q      <= act_l_d;
            act_r_q      <= act_r_d;
        end
    end

    assign ready_o        = ~pend_valid_q;
    assign bck_o          = bck_q;
    assign lrck_o         = lrck_q;
    assign data_o         = data_q;
    assign frame_o        = frame_q;
    assign underrun_o     = underrun_q;
    assign underrun_cnt_o = ucnt_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: cycle-accurate reference computed from elapsed mck
// cycles, table-driven phases, randomized traffic and hand-written corner cases.
module tb_i2s_tx;

    localparam int FR = 24;
    localparam int SL = 32;
    localparam int MD = 2;

    logic          mck   = 1'b0;
    logic          rst   = 1'b1;
    logic          valid = 1'b0;
    logic [FR-1:0] ldat  = '0;
    logic [FR-1:0] rdat  = '0;
    logic          ready, bck, lrck, sdata, frame, und;
    logic [7:0]    ucnt;

    logic          rst2 = 1'b1;
    logic          ready2, bck2, lrck2, sdata2, frame2, und2;
    logic [7:0]    ucnt2;

    i2s_tx #(.FRAME(FR), .SLOT(SL), .MCK_DIV(MD)) dut (
        .mck_i(mck), .rst_i(rst), .l_data_i(ldat), .r_data_i(rdat), .valid_i(valid),
        .ready_o(ready), .bck_o(bck), .lrck_o(lrck), .data_o(sdata), .frame_o(frame),
        .underrun_o(und), .underrun_cnt_o(ucnt)
    );

    // Small instance: 12 mck per frame, used for counter saturation.
    i2s_tx #(.FRAME(2), .SLOT(3), .MCK_DIV(1)) dut_s (
        .mck_i(mck), .rst_i(rst2), .l_data_i(2'b00), .r_data_i(2'b00), .valid_i(1'b0),
        .ready_o(ready2), .bck_o(bck2), .lrck_o(lrck2), .data_o(sdata2), .frame_o(frame2),
        .underrun_o(und2), .underrun_cnt_o(ucnt2)
    );

    always #5 mck = ~mck;

    int checks = 0;
    int errors = 0;

    // Reference state: n = mck edges since reset release.
    int            n = 0;
    bit            m_pend = 0, m_acc = 0, m_und = 0, m_frame = 0;
    logic [FR-1:0] m_pl = '0, m_pr = '0, m_al = '0, m_ar = '0;
    logic [7:0]    m_cnt = '0;

    typedef struct {
        logic rs;
        int   vmode;
        int   cycles;
        int   exp_cnt;
        logic exp_ready;
    } row_t;

    row_t rows[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (n=%0d, t=%0t)", name, act, exp, n, $time);
        end
    endtask

    task automatic model_edge(input logic rs, input logic v, input logic [FR-1:0] dl,
                              input logic [FR-1:0] dr);
        if (rs) begin
            n = 0; m_pend = 0; m_acc = 0; m_al = '0; m_ar = '0; m_cnt = '0;
            m_und = 0; m_frame = 0;
        end else begin
            m_acc = v && !m_pend;
            n++;
            m_und = 0;
            m_frame = 0;
            if (n % (2 * MD) == 0 && ((n / (2 * MD)) - 1) % (2 * SL) == 0) begin
                m_frame = 1;
                if (m_pend) begin
                    m_al = m_pl; m_ar = m_pr; m_pend = 0;
                end else begin
                    m_al = '0; m_ar = '0; m_und = 1;
                    if (m_cnt != 8'hFF) m_cnt++;
                end
            end
            if (m_acc) begin
                m_pl = dl; m_pr = dr; m_pend = 1;
            end
        end
    endtask

    function automatic logic [13:0] model_out();
        logic e_lr, e_d;
        int   kc;
        e_lr = 1'b1;
        e_d  = 1'b0;
        if (n >= 2 * MD) begin
            kc   = ((n / (2 * MD)) - 1) % (2 * SL);
            e_lr = (kc >= SL);
            if (kc >= 1 && kc <= FR) e_d = m_al[FR-kc];
            else if (kc >= SL + 1 && kc <= SL + FR) e_d = m_ar[SL+FR-kc];
        end
        return {~m_pend, 1'((n / MD) % 2), e_lr, e_d, m_frame, m_und, m_cnt};
    endfunction

    task automatic step(input logic rs, input logic v, input logic [FR-1:0] dl,
                        input logic [FR-1:0] dr);
        rst = rs; valid = v; ldat = dl; rdat = dr;
        @(posedge mck);
        model_edge(rs, v, dl, dr);
        @(negedge mck);
        check("outputs", {18'b0, ready, bck, lrck, sdata, frame, und, ucnt},
              {18'b0, model_out()});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, FR'($urandom), FR'($urandom));
    endtask

    initial begin
        logic [FR-1:0] lw, rw, seq;
        logic          pad;
        int            kc;

        rows[0] = '{rs: 1'b1, vmode: 0, cycles: 2,    exp_cnt: 0, exp_ready: 1'b1};
        rows[1] = '{rs: 1'b0, vmode: 0, cycles: 600,  exp_cnt: 3, exp_ready: 1'b1};
        rows[2] = '{rs: 1'b0, vmode: 1, cycles: 1024, exp_cnt: 3, exp_ready: 1'b0};
        rows[3] = '{rs: 1'b0, vmode: 0, cycles: 512,  exp_cnt: 4, exp_ready: 1'b1};

        @(negedge mck);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0);
        check("reset_ready", {31'b0, ready}, 32'd1);
        check("reset_cnt", {24'b0, ucnt}, 32'd0);

        // Pair accepted before the first frame start, then one full frame captured.
        step(1'b0, 1'b1, 24'h800001, 24'h7FFFFE);
        lw = '0; rw = '0; pad = 1'b0;
        while (n < 259) begin
            idle();
            if (n % (2 * MD) == 0) begin
                kc = (n / (2 * MD)) - 1;
                if (kc >= 1 && kc <= FR) lw = {lw[FR-2:0], sdata};
                else if (kc >= SL + 1 && kc <= SL + FR) rw = {rw[FR-2:0], sdata};
                else pad = pad | sdata;
            end
        end
        check("left_word", {8'b0, lw}, 32'h800001);
        check("right_word", {8'b0, rw}, 32'h7FFFFE);
        check("padding", {31'b0, pad}, 32'd0);
        check("no_underrun", {24'b0, ucnt}, 32'd0);

        seq = 24'h000100;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < rows[i].cycles; c++) begin
                if (rows[i].vmode == 1) begin
                    step(rows[i].rs, 1'b1, seq, ~seq);
                    if (m_acc) seq = seq + 1'b1;
                end else begin
                    step(rows[i].rs, 1'b0, FR'($urandom), FR'($urandom));
                end
            end
            check($sformatf("row%0d_cnt", i), {24'b0, ucnt}, 32'(rows[i].exp_cnt));
            check($sformatf("row%0d_ready", i), {31'b0, ready}, {31'b0, rows[i].exp_ready});
        end

        for (int c = 0; c < 3000; c++) begin
            step(1'b0, ($urandom_range(0, 99) < 2), FR'($urandom), FR'($urandom));
        end

        // Reset in the middle of a left slot that carries live data.
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, 24'hFFFFFF, 24'hFFFFFF);
        while (n < 44) idle();
        step(1'b1, 1'b0, '0, '0);
        check("midreset_outs", {26'b0, bck, lrck, sdata, frame, und, ready}, 32'b010001);
        check("midreset_cnt", {24'b0, ucnt}, 32'd0);
        for (int i = 0; i < 4; i++) idle();
        check("restart_frame", {28'b0, frame, und, lrck, sdata}, 32'b1100);

        // Valid offered only in the frame-start cycle: underrun now, data next frame.
        while (n < 259) idle();
        step(1'b0, 1'b1, 24'hA5C3E1, 24'h5A3C1E);
        check("accept_at_start", {30'b0, und, ready}, 32'b10);
        while (n < 520) idle();
        check("late_pair_msb", {31'b0, sdata}, 32'd1);
        while (n < 800) idle();

        rst2 = 1'b0;
        for (int c = 1; c <= 3602; c++) begin
            idle();
            if (c == 1190) check("sat_100", {24'b0, ucnt2}, 32'd100);
            if (c == 3049) check("sat_254", {24'b0, ucnt2}, 32'd254);
            if (c == 3050) check("sat_255", {24'b0, ucnt2}, 32'd255);
            if (c == 3602) check("sat_hold", {24'b0, ucnt2}, 32'd255);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
